// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined grouped carry-lookahead adder/subtractor; one GRP-bit group resolves per stage.
// Optional modular correction stage is built when CLA_MODRED_EN is defined.
module cla_pipe_addsub #(
    parameter int               WIDTH   = 64,
    parameter int               GRP     = 16,
    parameter logic [WIDTH-1:0] MODULUS = 64'hFFFFFFFF00000001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    input  logic             sub_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out
);

    localparam int NGRP = WIDTH / GRP;
    localparam int NBLK = GRP / 4;

    if ((WIDTH % GRP) != 0 || (GRP % 4) != 0) begin : g_param_check
        $error("cla_pipe_addsub: WIDTH must be a multiple of GRP and GRP a multiple of 4");
    end

    // One lookahead group: 4-bit CLA blocks whose block carries come from block P/G lookahead.
    function automatic logic [GRP:0] cla_group(input logic [GRP-1:0] a,
                                               input logic [GRP-1:0] b,
                                               input logic           cin);
        logic [GRP-1:0]  p;
        logic [GRP-1:0]  g;
        logic [GRP-1:0]  s;
        logic [NBLK-1:0] bp;
        logic [NBLK-1:0] bg;
        logic [NBLK:0]   bc;
        logic [3:0]      c;
        p = a ^ b;
        g = a & b;
        for (int j = 0; j < NBLK; j++) begin
            bp[j] = &p[4*j +: 4];
            bg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        end
        bc[0] = cin;
        for (int j = 0; j < NBLK; j++) begin
            bc[j+1] = bg[j] | (bp[j] & bc[j]);
        end
        for (int j = 0; j < NBLK; j++) begin
            c[0] = bc[j];
            for (int i = 0; i < 3; i++) begin
                c[i+1] = g[4*j+i] | (p[4*j+i] & c[i]);
            end
            s[4*j +: 4] = p[4*j +: 4] ^ c;
        end
        return {bc[NBLK], s};
    endfunction

    logic                  stall;
    logic [NGRP-1:0]       st_vld;
    logic [NGRP-1:0]       st_cy;
    logic [NGRP-1:0]       st_sub;
    logic [WIDTH-1:0]      st_a   [NGRP];
    logic [WIDTH-1:0]      st_b   [NGRP];
    logic [WIDTH-1:0]      st_sum [NGRP];
    logic [GRP:0]          grp_res [NGRP];
    logic [WIDTH-1:0]      nx_sum  [NGRP];

    logic                  res_vld;
    logic [WIDTH-1:0]      res_sum;
    logic                  res_c;
    logic                  fin_vld;
    logic [WIDTH-1:0]      fin_sum;
    logic                  fin_c;
    logic                  unused_tail;

    // A stalled output freezes the whole pipe, bubbles included.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    always_comb begin
        for (int k = 0; k < NGRP; k++) begin
            grp_res[k] = cla_group(st_a[k][k*GRP +: GRP], st_b[k][k*GRP +: GRP], st_cy[k]);
            nx_sum[k]  = st_sum[k];
            nx_sum[k][k*GRP +: GRP] = grp_res[k][GRP-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_vld <= '0;
        end else if (!stall) begin
            st_vld[0] <= in_valid;
            for (int k = 1; k < NGRP; k++) begin
                st_vld[k] <= st_vld[k-1];
            end
        end
    end

    // Subtraction enters as A + ~B + 1, so the stages never need to know the mode.
    always_ff @(posedge clk) begin
        if (!stall) begin
            st_a[0]   <= a_in;
            st_b[0]   <= sub_in ? ~b_in : b_in;
            st_cy[0]  <= sub_in | c_in;
            st_sub[0] <= sub_in;
            st_sum[0] <= '0;
            for (int k = 1; k < NGRP; k++) begin
                st_a[k]   <= st_a[k-1];
                st_b[k]   <= st_b[k-1];
                st_cy[k]  <= grp_res[k-1][GRP];
                st_sub[k] <= st_sub[k-1];
                st_sum[k] <= nx_sum[k-1];
            end
        end
    end

    assign res_vld     = st_vld[NGRP-1];
    assign res_sum     = nx_sum[NGRP-1];
    assign res_c       = grp_res[NGRP-1][GRP];
    assign unused_tail = ^{st_a[NGRP-1], st_b[NGRP-1]};

`ifdef CLA_MODRED_EN
    // Full-width grouped CLA, used once by the correction stage.
    function automatic logic [WIDTH:0] cla_full(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic             cin);
        logic [WIDTH-1:0] s;
        logic             cy;
        logic [GRP:0]     r;
        cy = cin;
        for (int k = 0; k < NGRP; k++) begin
            r              = cla_group(a[k*GRP +: GRP], b[k*GRP +: GRP], cy);
            s[k*GRP +: GRP] = r[GRP-1:0];
            cy             = r[GRP];
        end
        return {cy, s};
    endfunction

    logic             md_vld;
    logic             md_c;
    logic             md_sub;
    logic [WIDTH-1:0] md_sum;
    logic [WIDTH:0]   md_fix;
    logic             md_apply;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_vld <= 1'b0;
            md_c   <= 1'b0;
            md_sub <= 1'b0;
            md_sum <= '0;
        end else if (!stall) begin
            md_vld <= res_vld;
            if (res_vld) begin
                md_sum <= res_sum;
                md_c   <= res_c;
                md_sub <= st_sub[NGRP-1];
            end
        end
    end

    // Add: subtract MODULUS when {carry,sum} >= MODULUS. Sub: add MODULUS back after a borrow.
    always_comb begin
        md_fix   = cla_full(md_sum, md_sub ? MODULUS : ~MODULUS, !md_sub);
        md_apply = md_sub ? !md_c : (md_c | md_fix[WIDTH]);
    end

    assign fin_vld = md_vld;
    assign fin_sum = md_apply ? md_fix[WIDTH-1:0] : md_sum;
    assign fin_c   = md_apply;
`else
    logic unused_mod;

    assign unused_mod = ^{MODULUS, st_sub[NGRP-1]};
    assign fin_vld    = res_vld;
    assign fin_sum    = res_sum;
    assign fin_c      = res_c;
`endif

    // Result register keeps its last value whenever nothing valid arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum_out   <= '0;
            c_out     <= 1'b0;
        end else if (!stall) begin
            out_valid <= fin_vld;
            if (fin_vld) begin
                sum_out <= fin_sum;
                c_out   <= fin_c;
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed self-checking bench for cla_pipe_addsub (WIDTH=64, GRP=16).
// Define CLA_MODRED_EN for both DUT and bench to exercise the modular correction stage.
`timescale 1ns/1ps
module tb_cla_pipe_addsub;

`ifdef CLA_MODRED_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif
    localparam logic [63:0] MODULUS = 64'hFFFFFFFF00000001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a_in;
    logic [63:0] b_in;
    logic        c_in;
    logic        sub_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum_out;
    logic        c_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        logic [63:0] s;
        logic        c;
    } vec_t;

    vec_t vecs [7];

    cla_pipe_addsub #(.WIDTH(64), .GRP(16), .MODULUS(MODULUS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
        .sub_in    (sub_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .c_out     (c_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Sends one beat into an empty pipe and checks it surfaces exactly LAT cycles later.
    task automatic applyStimulus(input string tag, input vec_t v);
        a_in     = v.a;
        b_in     = v.b;
        c_in     = v.cin;
        sub_in   = v.sub;
        in_valid = 1'b1;
        @(negedge clk);
        checkOutput({tag, " in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            @(posedge clk);
            #1;
            if (i < LAT) checkOutput({tag, " early"}, 64'(out_valid), 64'd0);
        end
        checkOutput({tag, " out_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, " sum"}, sum_out, v.s);
        checkOutput({tag, " c_out"}, 64'(c_out), 64'(v.c));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   stale;
        bit   rose;
        vec_t v;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        c_in      = 1'b0;
        sub_in    = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #12;
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset sum_out", sum_out, 64'd0);
        checkOutput("reset c_out", 64'(c_out), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset idle valid", 64'(out_valid), 64'd0);

`ifndef CLA_MODRED_EN
        // Carry ripple, borrow and plain add/sub vectors
        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1};
        vecs[1] = '{64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
        vecs[2] = '{64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1};
        vecs[3] = '{64'h1234, 64'h1, 1'b1, 1'b0, 64'h1236, 1'b0};
        vecs[4] = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0};
        vecs[5] = '{64'hABCD, 64'hABCD, 1'b0, 1'b1, 64'd0, 1'b1};
        vecs[6] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        for (int i = 0; i < 7; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i]);
            @(posedge clk);
            #1;
        end
`else
        // Modular correction vectors
        vecs[0] = '{MODULUS - 64'd1, 64'd2, 1'b0, 1'b0, 64'd1, 1'b1};
        vecs[1] = '{64'd1, 64'd3, 1'b0, 1'b1, MODULUS - 64'd2, 1'b1};
        vecs[2] = '{64'd5, 64'd6, 1'b0, 1'b0, 64'd11, 1'b0};
        vecs[3] = '{64'd9, 64'd4, 1'b0, 1'b1, 64'd5, 1'b0};
        vecs[4] = '{MODULUS - 64'd1, MODULUS - 64'd1, 1'b0, 1'b0, MODULUS - 64'd2, 1'b1};
        vecs[5] = '{64'd7, 64'd7, 1'b0, 1'b1, 64'd0, 1'b0};
        vecs[6] = '{MODULUS - 64'd3, 64'd3, 1'b0, 1'b0, 64'd0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            applyStimulus($sformatf("mod%0d", i), vecs[i]);
            @(posedge clk);
            #1;
        end
`endif

        // Backpressure: six back-to-back beats, output stalled three cycles at first out_valid
        fork
            begin : bp_drv
                bit acc;
                for (int i = 0; i < 6; i++) begin
                    a_in     = 64'(i);
                    b_in     = 64'(i);
                    c_in     = 1'b1;
                    sub_in   = 1'b0;
                    in_valid = 1'b1;
                    acc      = 1'b0;
                    for (int w = 0; w < 50 && !acc; w++) begin
                        @(negedge clk);
                        #2;
                        acc = in_ready;
                        @(posedge clk);
                        #1;
                    end
                end
                in_valid = 1'b0;
            end
            begin : bp_mon
                int          got_n;
                int          stall_cnt;
                bit          seen;
                logic [63:0] hold;
                got_n     = 0;
                stall_cnt = 0;
                seen      = 1'b0;
                hold      = '0;
                for (int cyc = 0; cyc < 80 && got_n < 6; cyc++) begin
                    @(negedge clk);
                    #1;
                    if (out_valid && !seen) begin
                        seen      = 1'b1;
                        out_ready = 1'b0;
                        hold      = sum_out;
                    end else if (!out_ready) begin
                        stall_cnt++;
                        checkOutput("bp in_ready", 64'(in_ready), 64'd0);
                        checkOutput("bp hold", sum_out, hold);
                        checkOutput("bp valid", 64'(out_valid), 64'd1);
                        if (stall_cnt == 3) out_ready = 1'b1;
                    end
                    if (out_valid && out_ready) begin
                        checkOutput("bp order", sum_out, 64'(2 * got_n + 1));
                        checkOutput("bp c_out", 64'(c_out), 64'd0);
                        got_n++;
                    end
                end
                checkOutput("bp count", 64'(got_n), 64'd6);
                checkOutput("bp stall cycles", 64'(stall_cnt), 64'd3);
            end
        join
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        stale = 0;
        repeat (LAT + 2) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        checkOutput("bp no duplicate", 64'(stale), 64'd0);

        // Reset mid-flight: three beats in, reset pulsed once the first result shows
        for (int i = 0; i < 3; i++) begin
            a_in     = 64'(100 + i);
            b_in     = 64'd1;
            c_in     = 1'b0;
            sub_in   = 1'b0;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rose = 1'b0;
        for (int w = 0; w < 20 && !rose; w++) begin
            @(posedge clk);
            #1;
            rose = out_valid;
        end
        checkOutput("rst pre valid", 64'(rose), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst async valid", 64'(out_valid), 64'd0);
        checkOutput("rst async sum", sum_out, 64'd0);
        checkOutput("rst async c_out", 64'(c_out), 64'd0);
        #1;
        rst_n = 1'b1;
        stale = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        checkOutput("rst no stale", 64'(stale), 64'd0);
        checkOutput("rst in_ready", 64'(in_ready), 64'd1);
        v = '{64'd10, 64'd20, 1'b0, 1'b0, 64'd30, 1'b0};
        applyStimulus("rst recover", v);
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
